memblock_nport: RTL

//  Parametrised multi-read-port, single-write-port memory for the simple core (register file, small data RAMs).

---
 rtl/memblock_nport.sv | 110 +++++++++++
 1 files changed

// File: rtl/memblock_nport.sv
// Multi-read-port, single-write-port memory with byte-lane writes, optional registered reads,
// write-to-read bypass, hardwired-zero word 0 and a sequential clear engine gated by a ready flag.
module memblock_nport #(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 32,
    parameter  int NRD       = 2,
    parameter  int RD_REG    = 0,
    parameter  int BYPASS    = 1,
    parameter  int ZERO_REG0 = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*WIDTH-1:0]   rd_dout,
    input  logic                   we0,
    input  logic [AW-1:0]          wr_addr0,
    input  logic [WIDTH-1:0]       wr_din0,
    input  logic [WIDTH/8-1:0]     wr_be0,
    output logic                   ready,
    output logic                   wr_drop
);

    localparam int NB = WIDTH / 8;

    typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    clr_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             clearing;
    logic             wr_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] din,
                                               input logic [NB-1:0]    be);
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        end
        return r;
    endfunction

    // A write request is taken only in READY outside reset; requests seen while
    // clearing are refused and flagged one cycle later on wr_drop.
    assign clearing = (state == ST_CLEAR) && rst;
    assign wr_ok    = (state == ST_READY) && rst && we0 && addr_ok(wr_addr0);

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_CLEAR;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == AW'(DEPTH - 1)) state_next = ST_READY;
    end

    always_comb begin
        ready = (state == ST_READY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_cnt <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= (state == ST_CLEAR) && we0;
            if (state == ST_CLEAR) clr_cnt <= clr_cnt + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clearing)   mem[clr_cnt]  <= '0;
        else if (wr_ok) mem[wr_addr0] <= merge(mem[wr_addr0], wr_din0, wr_be0);
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] val;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            val = '0;
            if (state == ST_READY && addr_ok(ra)) begin
                val = mem[ra];
                if (BYPASS != 0 && wr_ok && wr_addr0 == ra) val = merge(mem[ra], wr_din0, wr_be0);
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk) begin
                if (!rst) q <= '0;
                else      q <= val;
            end
            assign rd_dout[k*WIDTH +: WIDTH] = q;
        end else begin : g_comb
            assign rd_dout[k*WIDTH +: WIDTH] = val;
        end
    end

endmodule
